// File: rtl/uart_framer_if.sv
// uart_framer_if -- bundles the TX/RX handshake and serial lines of uart_framer.
//   tx_data/tx_valid/tx_ready : byte hand-off into the transmitter
//   tx_out                    : serial output line, idle high
//   rx_in                     : asynchronous serial input line
//   rx_data/rx_valid/rx_ack   : received byte hand-off to the consumer
//   rx_frame_err/rx_parity_err: one-cycle error pulses
//   rx_over_run               : sticky lost-byte flag
// Modports: slave = the framer, master = the user of the framer.
interface uart_framer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_out;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_over_run;

  modport slave (
    input  tx_data, tx_valid, rx_in, rx_ack,
    output tx_ready, tx_out, rx_data, rx_valid,
           rx_frame_err, rx_parity_err, rx_over_run
  );

  modport master (
    output tx_data, tx_valid, rx_in, rx_ack,
    input  tx_ready, tx_out, rx_data, rx_valid,
           rx_frame_err, rx_parity_err, rx_over_run
  );
endinterface

// File: rtl/uart_framer.sv
// uart_framer -- UART transmitter and receiver sharing one clock.
// Ports:
//   clk   : sole clock for TX and RX
//   reset : synchronous, active-high
//   bus   : uart_framer_if.slave (TX byte hand-off, serial lines, RX byte
//           hand-off, error/over-run flags)
// Parameters: CLK_DIV (clk cycles per bit, 4..4095), DATA_BITS (5..8),
//   STOP_BITS (TX stop bits, 1 or 2), PARITY_ODD (0 even, 1 odd).
// Optional feature: define UART_PARITY_EN to add one parity bit after the
//   data bits on TX and check it on RX. Undefined: start + data + stop only,
//   rx_parity_err held at 0.
module uart_framer #(
  parameter int CLK_DIV    = 87,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         reset,
  uart_framer_if.slave bus
);

  localparam int               CNT_W     = 12;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  // Bit value that makes the total count of ones even (or odd).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_out_q;
  logic                 tx_ready_q;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_tick = (tx_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      // Every non-idle state lasts until the bit counter runs down to 0.
      if (tx_state_q != TX_IDLE && !tx_tick) tx_cnt_q <= tx_cnt_q - 1'b1;
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.tx_valid && tx_ready_q) begin
            tx_shift_q <= bus.tx_data;
`ifdef UART_PARITY_EN
            tx_par_q   <= parity_bit(bus.tx_data);
`endif
            tx_out_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_out_q   <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= BIT_LAST;
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
              tx_out_q   <= tx_par_q;
              tx_state_q <= TX_PARITY;
`else
              tx_out_q   <= 1'b1;
              tx_state_q <= TX_STOP;
`endif
            end else begin
              tx_out_q   <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_tick) begin
            tx_out_q   <= 1'b1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_bit_q == STOP_LAST) begin
              tx_ready_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_cnt_q <= BIT_LAST;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q;
  logic                 rx_sync1_q;
  logic                 rx_sync2_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_ferr_q;
  logic                 rx_ovr_q;
  logic                 rx_tick;
  logic                 rx_keep;
`ifdef UART_PARITY_EN
  logic                 rx_perr_q;
  logic                 rx_pbad_q;
  assign rx_keep = !rx_pbad_q;
`else
  assign rx_keep = 1'b1;
`endif

  assign rx_tick = (rx_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
      rx_pbad_q  <= 1'b0;
`endif
    end else begin
      rx_sync1_q <= bus.rx_in;
      rx_sync2_q <= rx_sync1_q;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
      // An ack is honoured only while a byte is pending; a byte completing
      // in the same cycle overrides this below, so new data wins.
      if (bus.rx_ack && rx_valid_q) rx_valid_q <= 1'b0;
      if (rx_state_q != RX_IDLE && !rx_tick) rx_cnt_q <= rx_cnt_q - 1'b1;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync2_q) begin
            rx_cnt_q   <= HALF_LAST;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_sync2_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_bit_q   <= '0;
              rx_cnt_q   <= BIT_LAST;
              rx_state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            // Shift in at the top so the first (LSB) bit ends up at bit 0.
            rx_shift_q <= {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_cnt_q   <= BIT_LAST;
            if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PARITY;
`else
              rx_state_q <= RX_STOP;
`endif
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_tick) begin
            rx_pbad_q  <= (rx_sync2_q != parity_bit(rx_shift_q));
            rx_perr_q  <= (rx_sync2_q != parity_bit(rx_shift_q));
            rx_cnt_q   <= BIT_LAST;
            rx_state_q <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_tick) begin
            // Back to idle at mid-stop so the next start edge is not missed.
            rx_state_q <= RX_IDLE;
            if (!rx_sync2_q) begin
              rx_ferr_q <= 1'b1;
            end else if (rx_keep) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !bus.rx_ack) rx_ovr_q <= 1'b1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.tx_out       = tx_out_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;
  assign bus.rx_over_run  = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = rx_perr_q;
`else
  logic unused_par_cfg;
  assign unused_par_cfg    = (PARITY_ODD != 0);
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule
